// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NUM_PORTS = 2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_NE  = 4'b1001;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-requester arbiter. With ALU_ARB_RR_EN defined it is round-robin with a
// last-grant pointer (reset to port 1 so port 0 wins first contention);
// otherwise it is fixed priority, port 0 over port 1, with no pointer state.
module rr_arbiter2
  import alu_arb_pkg::*;
(
`ifdef ALU_ARB_RR_EN
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 update,
`endif
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

`ifdef ALU_ARB_RR_EN
  logic last_q;
  logic last_d;

  // Pointer register: remembers which port was granted most recently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // Grant selection: on contention, favour the port not granted last
  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
    last_d = last_q;
    if (update) begin
      last_d = gnt[1];
    end
  end
`else
  // Grant selection: port 0 always wins on contention
  always_comb begin
    gnt = '0;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Two-port scheduler sharing one combinational ALU. One operation in flight:
// IDLE accepts, EXEC drives the ALU from registered operands, RESP holds the
// result until the granted port takes it. Config macro: ALU_ARB_RR_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS*OPCODE_LENGTH-1:0] req_op,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_b,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_data,
  input  logic [NUM_PORTS-1:0]             resp_ready,
  output logic [OPCODE_LENGTH-1:0]         alu_op,
  output logic [DATA_WIDTH-1:0]            alu_srca,
  output logic [DATA_WIDTH-1:0]            alu_srcb,
  input  logic [DATA_WIDTH-1:0]            alu_result
);

  state_t                   state_q, state_d;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0]    a_q, a_d;
  logic [DATA_WIDTH-1:0]    b_q, b_d;
  logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;
  logic                     grant_q, grant_d;

  logic [NUM_PORTS-1:0] gnt;
  logic                 accept;
  logic                 win;

  assign accept = (state_q == IDLE) && (|req_valid);
  assign win    = gnt[1];

  rr_arbiter2 u_arb (
`ifdef ALU_ARB_RR_EN
    .clk    (clk),
    .rst_n  (rst_n),
    .update (accept),
`endif
    .req    (req_valid),
    .gnt    (gnt)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      resp_data_q <= '0;
      grant_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      resp_data_q <= resp_data_d;
      grant_q     <= grant_d;
    end
  end

  // Next state and next datapath values
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    resp_data_d = resp_data_q;
    grant_d     = grant_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = win ? req_op[2*OPCODE_LENGTH-1:OPCODE_LENGTH] : req_op[OPCODE_LENGTH-1:0];
          a_d     = win ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
          b_d     = win ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
          grant_d = win;
          state_d = EXEC;
        end
      end
      EXEC: begin
        resp_data_d = alu_result;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_ready[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (state_q == IDLE) begin
      req_ready = gnt;
    end
    if (state_q == RESP) begin
      resp_valid[grant_q] = 1'b1;
    end
  end

  assign alu_op    = op_q;
  assign alu_srca  = a_q;
  assign alu_srcb  = b_q;
  assign resp_data = resp_data_q;

endmodule
